d_mem_lsu: RTL and testbench



---
 rtl/d_mem_lsu.sv | 185 ++++++++++++++++++
 tb/tb_d_mem_lsu.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/d_mem_lsu.sv
// d_mem_lsu: load/store initiator for the word-aligned data memory port.
// One request at a time is accepted through a valid/ready handshake.
// Accesses crossing a word boundary are split into two memory accesses.
// Read fragments are merged, then sign- or zero-extended.
// The response is registered and returned one cycle after the last access.
// Optional feature macro D_MEM_LSU_MISALIGN_TRAP_EN: crossing requests are
// rejected with resp_err instead of being split.
module d_mem_lsu #(
    parameter int WORD_WIDTH = 32,
    parameter int ADRS_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [1:0]              req_size,
    input  logic                    req_sign_ext,
    input  logic [ADRS_WIDTH-1:0]   req_adrs,
    input  logic [WORD_WIDTH-1:0]   req_wr_data,
    output logic                    resp_valid,
    output logic [WORD_WIDTH-1:0]   resp_rd_data,
    output logic                    resp_err,
    output logic [ADRS_WIDTH-1:0]   mem_adrs,
    output logic                    mem_rden,
    output logic                    mem_wren,
    output logic [WORD_WIDTH/8-1:0] mem_byt_en,
    output logic                    mem_sign_ext,
    output logic [WORD_WIDTH-1:0]   mem_wr_data,
    input  logic [WORD_WIDTH-1:0]   mem_rd_data
);

    typedef enum logic {IDLE, SPLIT} state_t;

    state_t state, next_state;

    // Request fields held across the second half of a split access
    logic                  s_we_p1;
    logic [1:0]            s_size_p1;
    logic                  s_sign_p1;
    logic [ADRS_WIDTH-3:0] s_word_adrs_p1;
    logic [WORD_WIDTH-1:0] s_wr_data_p1;
    logic [1:0]            s_k_p1;
    logic [3:0]            s_mask_p1;
    logic [WORD_WIDTH-1:0] partial_p1;

    logic [1:0]            off;
    logic [1:0]            k_now;
    logic                  crossing;
    logic                  reject;
    logic                  accept;
    logic [ADRS_WIDTH-3:0] next_word;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            2'b10:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // Data mask covering the lowest k byte lanes
    function automatic logic [WORD_WIDTH-1:0] low_bytes(input logic [1:0] k);
        return ~({WORD_WIDTH{1'b1}} << {k, 3'b000});
    endfunction

    function automatic logic [WORD_WIDTH-1:0] extend(
        input logic [WORD_WIDTH-1:0] data,
        input logic [1:0]            size,
        input logic                  sign
    );
        case (size)
            2'b00:   return {{(WORD_WIDTH-8){sign & data[7]}}, data[7:0]};
            2'b01:   return {{(WORD_WIDTH-16){sign & data[15]}}, data[15:0]};
            default: return data;
        endcase
    endfunction

    assign off          = req_adrs[1:0];
    assign k_now        = 2'd0 - off;  // bytes left in the first word: 4 - off
    assign crossing     = (({1'b0, off}) + size_bytes(req_size)) > 3'd4;
    assign accept       = req_valid && (state == IDLE);
    assign next_word    = s_word_adrs_p1 + (ADRS_WIDTH-2)'(1);
    assign mem_sign_ext = 1'b0;

`ifdef D_MEM_LSU_MISALIGN_TRAP_EN
    assign reject = (req_size == 2'b11) || crossing;
`else
    assign reject = (req_size == 2'b11);
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next state and memory port drive
    always_comb begin
        next_state  = state;
        req_ready   = (state == IDLE);
        mem_adrs    = req_adrs;
        mem_rden    = 1'b0;
        mem_wren    = 1'b0;
        mem_byt_en  = '0;
        mem_wr_data = req_wr_data;
        case (state)
            IDLE: begin
                if (accept && !reject) begin
                    mem_byt_en = size_mask(req_size);
                    mem_rden   = ~req_we;
                    mem_wren   = req_we;
                    if (crossing) next_state = SPLIT;
                end
            end
            SPLIT: begin
                mem_adrs    = {next_word, 2'b00};
                mem_byt_en  = s_mask_p1 >> s_k_p1;
                mem_wr_data = s_wr_data_p1 >> {s_k_p1, 3'b000};
                mem_rden    = ~s_we_p1;
                mem_wren    = s_we_p1;
                next_state  = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Response generation, first-half capture and request save
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid     <= 1'b0;
            resp_err       <= 1'b0;
            resp_rd_data   <= '0;
            s_we_p1        <= 1'b0;
            s_size_p1      <= 2'b00;
            s_sign_p1      <= 1'b0;
            s_word_adrs_p1 <= '0;
            s_wr_data_p1   <= '0;
            s_k_p1         <= 2'b00;
            s_mask_p1      <= 4'b0000;
            partial_p1     <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    if (reject) begin
                        resp_valid   <= 1'b1;
                        resp_err     <= 1'b1;
                        resp_rd_data <= '0;
                    end else if (crossing) begin
                        s_we_p1        <= req_we;
                        s_size_p1      <= req_size;
                        s_sign_p1      <= req_sign_ext;
                        s_word_adrs_p1 <= req_adrs[ADRS_WIDTH-1:2];
                        s_wr_data_p1   <= req_wr_data;
                        s_k_p1         <= k_now;
                        s_mask_p1      <= size_mask(req_size);
                        partial_p1     <= mem_rd_data & low_bytes(k_now);
                    end else begin
                        resp_valid   <= 1'b1;
                        resp_rd_data <= req_we ? '0
                                      : extend(mem_rd_data, req_size, req_sign_ext);
                    end
                end
            end else begin
                resp_valid   <= 1'b1;
                resp_rd_data <= s_we_p1 ? '0
                              : extend(partial_p1 | (mem_rd_data << {s_k_p1, 3'b000}),
                                       s_size_p1, s_sign_p1);
            end
        end
    end

endmodule

// File: tb/tb_d_mem_lsu.sv
// Directed testbench for d_mem_lsu with a byte-lane data memory model.
module tb_d_mem_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_sign_ext = 1'b0;
    logic [31:0] req_adrs = 32'h0;
    logic [31:0] req_wr_data = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rd_data;
    logic        resp_err;
    logic [31:0] mem_adrs;
    logic        mem_rden;
    logic        mem_wren;
    logic [3:0]  mem_byt_en;
    logic        mem_sign_ext;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;

    logic [31:0] mem_w [0:63];
    logic        load_req = 1'b0;

    int checks = 0;
    int errors = 0;

    d_mem_lsu #(.WORD_WIDTH(32), .ADRS_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_sign_ext(req_sign_ext), .req_adrs(req_adrs),
        .req_wr_data(req_wr_data),
        .resp_valid(resp_valid), .resp_rd_data(resp_rd_data), .resp_err(resp_err),
        .mem_adrs(mem_adrs), .mem_rden(mem_rden), .mem_wren(mem_wren),
        .mem_byt_en(mem_byt_en), .mem_sign_ext(mem_sign_ext),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    // Word memory: read data shifted down to the addressed byte, lanes past the word dropped
    assign mem_rd_data = mem_w[mem_adrs[7:2]] >> {mem_adrs[1:0], 3'b000};

    always @(posedge clk) begin
        if (load_req) begin
            mem_w[4] <= 32'h44332211;
            mem_w[5] <= 32'h88776655;
        end else if (mem_wren) begin
            for (int i = 0; i < 4; i++)
                if (mem_byt_en[i] && (i + int'(mem_adrs[1:0])) < 4)
                    mem_w[mem_adrs[7:2]][8*(i+int'(mem_adrs[1:0])) +: 8] <= mem_wr_data[8*i +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [1:0] size, input logic sx,
                         input logic [31:0] adrs, input logic [31:0] wd);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_sign_ext = sx;
        req_adrs     = adrs;
        req_wr_data  = wd;
    endtask

    initial begin
        // Reset and memory preload
        load_req = 1'b1;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'h1);
        check("rst_rden", 32'(mem_rden), 32'h0);
        check("rst_wren", 32'(mem_wren), 32'h0);
        check("rst_byt_en", 32'(mem_byt_en), 32'h0);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'h0);
        check("rst_resp_data", resp_rd_data, 32'h0);
        tick();
        tick();
        load_req = 1'b0;
        rst_n = 1'b1;
        tick();
        check("sign_ext_port", 32'(mem_sign_ext), 32'h0);

`ifdef D_MEM_LSU_MISALIGN_TRAP_EN
        // Trap build: crossing word load is rejected
        drive(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
        #1;
        check("trap_rden", 32'(mem_rden), 32'h0);
        check("trap_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 1'b0;
        check("trap_err", 32'(resp_err), 32'h1);
        check("trap_data", resp_rd_data, 32'h0);
        #1;
        check("trap_no_split", 32'(mem_rden), 32'h0);
        tick();
`else
        // 1: byte loads, signed then unsigned
        drive(1'b0, 2'b00, 1'b1, 32'h17, 32'h0);
        #1;
        check("lb_rden", 32'(mem_rden), 32'h1);
        check("lb_byt_en", 32'(mem_byt_en), 32'h1);
        check("lb_adrs", mem_adrs, 32'h17);
        tick();
        check("lbs_valid", 32'(resp_valid), 32'h1);
        check("lbs_data", resp_rd_data, 32'hFFFFFF88);
        drive(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        #1;
        check("lbu_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 1'b0;
        check("lbu_data", resp_rd_data, 32'h00000044);

        // 2: crossing word load
        tick();
        drive(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
        #1;
        check("lw1_adrs", mem_adrs, 32'h12);
        check("lw1_byt_en", 32'(mem_byt_en), 32'hF);
        tick();
        req_valid = 1'b0;
        #1;
        check("lw2_ready", 32'(req_ready), 32'h0);
        check("lw2_adrs", mem_adrs, 32'h14);
        check("lw2_byt_en", 32'(mem_byt_en), 32'h3);
        check("lw2_rden", 32'(mem_rden), 32'h1);
        check("lw2_no_resp", 32'(resp_valid), 32'h0);
        tick();
        check("lw_valid", 32'(resp_valid), 32'h1);
        check("lw_data", resp_rd_data, 32'h66554433);
        check("lw_err", 32'(resp_err), 32'h0);

        // 3: crossing half store
        drive(1'b1, 2'b01, 1'b0, 32'h13, 32'h0000BEEF);
        #1;
        check("sh1_wren", 32'(mem_wren), 32'h1);
        check("sh1_byt_en", 32'(mem_byt_en), 32'h3);
        tick();
        req_valid = 1'b0;
        #1;
        check("sh2_byt_en", 32'(mem_byt_en), 32'h1);
        check("sh2_wr_data", mem_wr_data, 32'h000000BE);
        tick();
        check("sh_valid", 32'(resp_valid), 32'h1);
        check("sh_data", resp_rd_data, 32'h0);
        check("sh_word10", mem_w[4], 32'hEF332211);
        check("sh_word14", mem_w[5], 32'h887766BE);

        // 4: back-to-back half loads
        drive(1'b0, 2'b01, 1'b0, 32'h16, 32'h0);
        tick();
        check("lhu_data", resp_rd_data, 32'h00008877);
        drive(1'b0, 2'b01, 1'b1, 32'h16, 32'h0);
        #1;
        check("lh_b2b_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 1'b0;
        check("lhs_valid", 32'(resp_valid), 32'h1);
        check("lhs_data", resp_rd_data, 32'hFFFF8877);
        tick();
        check("lh_idle_valid", 32'(resp_valid), 32'h0);

        // 5: reset during the second half of a crossing store
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        drive(1'b1, 2'b10, 1'b0, 32'h11, 32'hDDCCBBAA);
        tick();
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("sw_rst_wren", 32'(mem_wren), 32'h0);
        check("sw_word10", mem_w[4], 32'hCCBBAA11);
        tick();
        rst_n = 1'b1;
        tick();
        check("sw_no_resp", 32'(resp_valid), 32'h0);
        check("sw_ready", 32'(req_ready), 32'h1);
        check("sw_word14", mem_w[5], 32'h88776655);
`endif

        // 6: reserved size
        drive(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        #1;
        check("rsv_rden", 32'(mem_rden), 32'h0);
        check("rsv_wren", 32'(mem_wren), 32'h0);
        check("rsv_byt_en", 32'(mem_byt_en), 32'h0);
        tick();
        req_valid = 1'b0;
        check("rsv_err", 32'(resp_err), 32'h1);
        check("rsv_data", resp_rd_data, 32'h0);
        #1;
        check("rsv_ready", 32'(req_ready), 32'h1);
        tick();
        check("rsv_err_pulse", 32'(resp_err), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
